// File: rtl/uart_rx_sample.sv
// UART receiver that samples each bit at its mid-point and pairs consecutive bytes
// into 16-bit samples, indexed within an N-sample frame.
module uart_rx_sample #(
    parameter int CLKS_PER_BIT = 10,
    parameter int N            = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic [15:0]       data_o,
    output logic              data_valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              frame_done_o,
    output logic              frame_err_o
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic              rx_m;
    logic              rx_s;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_byte;
    logic [7:0]        low_byte;
    logic              pair_tog;
    logic              wait_high;
    logic [ADDR_W-1:0] sample_cnt;
    logic              bit_tick;
    logic              stop_tick;
    logic              take_low;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        bit_tick  = (state == DATA) && (cnt == FULL_M1);
        stop_tick = (state == STOP) && (cnt == FULL_M1);
        take_low  = stop_tick && rx_s && !pair_tog;
    end

    // Byte datapath: assembled bits and the held first byte of a pair
    always_ff @(posedge clk) begin
        if (bit_tick)
            shift_byte[bit_idx] <= rx_s;
        if (take_low)
            low_byte <= shift_byte;
    end

    // Control FSM and registered output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            pair_tog     <= 1'b0;
            wait_high    <= 1'b0;
            sample_cnt   <= '0;
            data_o       <= '0;
            addr_o       <= '0;
            data_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            frame_done_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    // After a stop-bit error the line must go high before a new start counts
                    if (wait_high) begin
                        if (rx_s)
                            wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state       <= IDLE;
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_tick) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err_o <= 1'b1;
                            pair_tog    <= 1'b0;
                            wait_high   <= 1'b1;
                        end else if (!pair_tog) begin
                            pair_tog <= 1'b1;
                        end else begin
                            data_o       <= {shift_byte, low_byte};
                            addr_o       <= sample_cnt;
                            data_valid_o <= 1'b1;
                            frame_done_o <= (sample_cnt == LAST);
                            pair_tog     <= 1'b0;
                            sample_cnt   <= (sample_cnt == LAST) ? '0 : sample_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sample.sv
// Bench for uart_rx_sample: a 256-sample and a 4-sample instance share one serial line
// and are checked against a byte-level model of pairing, indexing and frame errors.
module tb_uart_rx_sample;

    localparam int C = 10;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  a;
        logic        f;
        logic [31:0] t;
    } smp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_i  = 1'b1;
    logic [15:0] d0, d1;
    logic [7:0]  a0;
    logic [1:0]  a1;
    logic        v0, v1, fd0, fd1, fe0, fe1;

    int   cyc = 0;
    smp_t obs0[$], obs1[$], exp0[$], exp1[$];
    int   err0 = 0, err1 = 0, stray0 = 0, stray1 = 0;
    int   o0 = 0, o1 = 0, e0 = 0, e1 = 0;
    int   tests_run = 0, tests_failed = 0;

    int          m_tog[2];
    logic [7:0]  m_low[2];
    int          m_cnt[2];
    int          m_err = 0;
    int          nn[2] = '{256, 4};

    uart_rx_sample #(.CLKS_PER_BIT(C), .N(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .data_o(d0), .data_valid_o(v0),
        .addr_o(a0), .frame_done_o(fd0), .frame_err_o(fe0));

    uart_rx_sample #(.CLKS_PER_BIT(C), .N(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx_i), .data_o(d1), .data_valid_o(v1),
        .addr_o(a1), .frame_done_o(fd1), .frame_err_o(fe1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) obs0.push_back('{d: d0, a: a0, f: fd0, t: 32'(cyc)});
        if (v1) obs1.push_back('{d: d1, a: {6'b0, a1}, f: fd1, t: 32'(cyc)});
        if (fd0 && !v0) stray0++;
        if (fd1 && !v1) stray1++;
        if (fe0) err0++;
        if (fe1) err1++;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got no end want end");
        $fatal(1);
    end

    // Byte-level model: pairs bytes, numbers samples modulo N, drops the pair on a bad stop
    task automatic model_byte(input logic [7:0] b, input bit ok, input int stop_edge);
        if (!ok) m_err++;
        for (int u = 0; u < 2; u++) begin
            if (!ok) begin
                m_tog[u] = 0;
            end else if (m_tog[u] == 0) begin
                m_low[u] = b;
                m_tog[u] = 1;
            end else begin
                smp_t e;
                e.d = {b, m_low[u]};
                e.a = 8'(m_cnt[u]);
                e.f = (m_cnt[u] == nn[u] - 1);
                e.t = 32'(stop_edge + C / 2 + 3);
                if (u == 0) exp0.push_back(e); else exp1.push_back(e);
                m_cnt[u] = (m_cnt[u] + 1) % nn[u];
                m_tog[u] = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_tog = '{0, 0};
        m_cnt = '{0, 0};
    endtask

    task automatic sync_idx();
        o0 = obs0.size(); o1 = obs1.size();
        e0 = exp0.size(); e1 = exp1.size();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_i = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok, input logic after);
        int s;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        s = cyc;
        drive_bit(ok);
        rx_i = after;
        model_byte(b, ok, s);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_i  = 1'b1;
        idle(3);
        rst_n = 1'b1;
        model_reset();
        sync_idx();
        idle(5);
    endtask

    task automatic test_reset();
        rx_i = 1'b1;
        idle(3);
        tests_run++;
        if ({d0, a0, v0, fd0, fe0} !== 27'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_n256: got %h want 0", {d0, a0, v0, fd0, fe0});
        end
        tests_run++;
        if ({d1, a1, v1, fd1, fe1} !== 21'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_n4: got %h want 0", {d1, a1, v1, fd1, fe1});
        end
        rst_n = 1'b1;
        model_reset();
        idle(20);
        tests_run++;
        if (obs0.size() != 0 || err0 != 0) begin
            tests_failed++;
            $display("FAIL reset_idle_quiet: got %0d strobes %0d errors want 0 0", obs0.size(), err0);
        end
        sync_idx();
    endtask

    task automatic test_single_pair();
        int ne = err0;
        send_byte(8'h34, 1, 1'b1);
        send_byte(8'h12, 1, 1'b1);
        idle(10);
        tests_run++;
        if (obs0.size() - o0 != 1) begin
            tests_failed++;
            $display("FAIL pair_count: got %0d want 1", obs0.size() - o0);
        end
        tests_run++;
        if (obs0[o0].d !== 16'h1234) begin
            tests_failed++;
            $display("FAIL pair_data: got %h want 1234", obs0[o0].d);
        end
        tests_run++;
        if (obs0[o0].a !== 8'd0 || obs0[o0].f !== 1'b0) begin
            tests_failed++;
            $display("FAIL pair_addr_done: got %0d/%b want 0/0", obs0[o0].a, obs0[o0].f);
        end
        tests_run++;
        if (obs0[o0].t !== exp0[e0].t) begin
            tests_failed++;
            $display("FAIL pair_latency: got cycle %0d want %0d", obs0[o0].t, exp0[e0].t);
        end
        tests_run++;
        if (err0 != ne) begin
            tests_failed++;
            $display("FAIL pair_no_err: got %0d want %0d", err0, ne);
        end
        sync_idx();
    endtask

    task automatic test_ramp();
        apply_reset();
        for (int k = 0; k < 256; k++) begin
            send_byte(8'(k), 1, 1'b1);
            send_byte(8'(k), 1, 1'b1);
        end
        send_byte(8'hAB, 1, 1'b1);
        send_byte(8'hCD, 1, 1'b1);
        idle(10);
        tests_run++;
        if (obs0.size() - o0 != 257) begin
            tests_failed++;
            $display("FAIL ramp_count: got %0d want 257", obs0.size() - o0);
        end
        for (int k = 0; k < 257; k++) begin
            smp_t want;
            want.d = (k < 256) ? 16'(16'h0101 * k) : 16'hCDAB;
            want.a = 8'(k % 256);
            want.f = (k == 255);
            want.t = exp0[e0 + k].t;
            tests_run++;
            if (obs0[o0 + k] !== want) begin
                tests_failed++;
                $display("FAIL ramp_sample_%0d: got d=%h a=%0d f=%b t=%0d want d=%h a=%0d f=%b t=%0d", k,
                         obs0[o0 + k].d, obs0[o0 + k].a, obs0[o0 + k].f, obs0[o0 + k].t,
                         want.d, want.a, want.f, want.t);
            end
        end
        sync_idx();
    endtask

    task automatic test_stop_error();
        int ne    = err0;
        int a_exp = m_cnt[0];
        send_byte(8'h99, 1, 1'b1);
        send_byte(8'hA5, 0, 1'b1);
        idle(5);
        send_byte(8'h11, 1, 1'b1);
        send_byte(8'h22, 1, 1'b1);
        idle(10);
        tests_run++;
        if (err0 - ne != 1) begin
            tests_failed++;
            $display("FAIL stoperr_pulses: got %0d want 1", err0 - ne);
        end
        tests_run++;
        if (obs0.size() - o0 != 1) begin
            tests_failed++;
            $display("FAIL stoperr_count: got %0d want 1", obs0.size() - o0);
        end
        tests_run++;
        if (obs0[o0].d !== 16'h2211 || obs0[o0].a !== 8'(a_exp)) begin
            tests_failed++;
            $display("FAIL stoperr_sample: got %h@%0d want 2211@%0d", obs0[o0].d, obs0[o0].a, a_exp);
        end
        sync_idx();
    endtask

    task automatic test_glitch();
        int ne = err0;
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        m_err++;
        idle(30);
        tests_run++;
        if (err0 - ne != 1 || obs0.size() != o0) begin
            tests_failed++;
            $display("FAIL glitch_err: got %0d errors %0d strobes want 1 0", err0 - ne, obs0.size() - o0);
        end
        send_byte(8'h5A, 1, 1'b1);
        send_byte(8'hC3, 1, 1'b1);
        idle(10);
        tests_run++;
        if (obs0.size() - o0 != 1 || obs0[o0].d !== 16'hC35A || err0 - ne != 1) begin
            tests_failed++;
            $display("FAIL glitch_recover: got %0d strobes d=%h want 1 strobe d=c35a", obs0.size() - o0, obs0[o0].d);
        end
        sync_idx();
    endtask

    task automatic test_line_low();
        int ne = err0;
        send_byte(8'h3C, 0, 1'b0);
        idle(150);
        rx_i = 1'b1;
        idle(10);
        send_byte(8'hEE, 1, 1'b1);
        send_byte(8'h77, 1, 1'b1);
        idle(10);
        tests_run++;
        if (err0 - ne != 1) begin
            tests_failed++;
            $display("FAIL linelow_err: got %0d want 1", err0 - ne);
        end
        tests_run++;
        if (obs0.size() - o0 != 1 || obs0[o0].d !== 16'h77EE) begin
            tests_failed++;
            $display("FAIL linelow_sample: got %0d strobes d=%h want 1 d=77ee", obs0.size() - o0, obs0[o0].d);
        end
        sync_idx();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h4D;
        send_byte(8'h9A, 1, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_i = b[4];
        idle(5);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({d0, a0, v0, fd0, fe0} !== 27'd0 || {d1, a1, v1, fd1, fe1} !== 21'd0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %h %h want 0 0", {d0, a0, v0, fd0, fe0}, {d1, a1, v1, fd1, fe1});
        end
        rx_i = 1'b1;
        idle(3);
        rst_n = 1'b1;
        model_reset();
        sync_idx();
        idle(10);
        send_byte(8'h78, 1, 1'b1);
        send_byte(8'h56, 1, 1'b1);
        idle(10);
        tests_run++;
        if (obs0.size() - o0 != 1 || obs0[o0].d !== 16'h5678 || obs0[o0].a !== 8'd0) begin
            tests_failed++;
            $display("FAIL rstmid_pair: got %0d strobes %h@%0d want 1 5678@0", obs0.size() - o0, obs0[o0].d, obs0[o0].a);
        end
        sync_idx();
    endtask

    task automatic test_frame_n4();
        int nd = 0;
        apply_reset();
        for (int p = 0; p < 16; p++) send_byte(8'($urandom), 1, 1'b1);
        idle(10);
        tests_run++;
        if (obs1.size() - o1 != 8) begin
            tests_failed++;
            $display("FAIL n4_count: got %0d want 8", obs1.size() - o1);
        end
        for (int i = 0; i < 8; i++) begin
            nd += int'(obs1[o1 + i].f);
            tests_run++;
            if (obs1[o1 + i] !== exp1[e1 + i] || obs1[o1 + i].a !== 8'(i % 4)) begin
                tests_failed++;
                $display("FAIL n4_sample_%0d: got %h@%0d f=%b want %h@%0d f=%b", i, obs1[o1 + i].d,
                         obs1[o1 + i].a, obs1[o1 + i].f, exp1[e1 + i].d, i % 4, exp1[e1 + i].f);
            end
        end
        tests_run++;
        if (nd != 2) begin
            tests_failed++;
            $display("FAIL n4_frame_done: got %0d pulses want 2", nd);
        end
        sync_idx();
    endtask

    task automatic test_back_to_back();
        int ne = err0;
        int me = m_err;
        int nx0, nx1;
        for (int i = 0; i < 40; i++) begin
            bit ok  = ($urandom_range(7) != 0);
            int gap = $urandom_range(12);
            send_byte(8'($urandom), ok, 1'b1);
            if (!ok && gap < 2) gap = 2;
            if (gap > 0) idle(gap);
        end
        idle(10);
        nx0 = exp0.size() - e0;
        nx1 = exp1.size() - e1;
        tests_run++;
        if (obs0.size() - o0 != nx0 || obs1.size() - o1 != nx1) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d/%0d want %0d/%0d", obs0.size() - o0, obs1.size() - o1, nx0, nx1);
        end
        for (int i = 0; i < nx0; i++) begin
            tests_run++;
            if (obs0[o0 + i] !== exp0[e0 + i]) begin
                tests_failed++;
                $display("FAIL b2b_n256_%0d: got %h@%0d t=%0d want %h@%0d t=%0d", i, obs0[o0 + i].d,
                         obs0[o0 + i].a, obs0[o0 + i].t, exp0[e0 + i].d, exp0[e0 + i].a, exp0[e0 + i].t);
            end
        end
        for (int i = 0; i < nx1; i++) begin
            tests_run++;
            if (obs1[o1 + i] !== exp1[e1 + i]) begin
                tests_failed++;
                $display("FAIL b2b_n4_%0d: got %h@%0d f=%b want %h@%0d f=%b", i, obs1[o1 + i].d,
                         obs1[o1 + i].a, obs1[o1 + i].f, exp1[e1 + i].d, exp1[e1 + i].a, exp1[e1 + i].f);
            end
        end
        tests_run++;
        if (err0 - ne != m_err - me) begin
            tests_failed++;
            $display("FAIL b2b_errors: got %0d want %0d", err0 - ne, m_err - me);
        end
        tests_run++;
        if (stray0 != 0 || stray1 != 0 || err1 != err0) begin
            tests_failed++;
            $display("FAIL stray_strobes: got done-without-valid %0d/%0d err %0d/%0d want 0/0 equal",
                     stray0, stray1, err0, err1);
        end
        sync_idx();
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_ramp();
        test_stop_error();
        test_glitch();
        test_line_low();
        test_reset_mid();
        test_frame_n4();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_sample.md
UART_RX_SAMPLE -- requirements
Module: uart_rx_sample

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clk cycles per UART bit.
REQ-002 SHALL have parameter N, default 256, meaning 16-bit samples per frame.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning width of sample index (log2 N).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port rx_i, input, 1, meaning serial line: idle high, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-007 SHALL have port data_o, output, 16, meaning assembled sample {second byte, first byte}.
REQ-008 SHALL have port data_valid_o, output, 1, meaning one-cycle strobe qualifying data_o/addr_o.
REQ-009 SHALL have port addr_o, output, ADDR_W, meaning sample index within frame, 0..N-1.
REQ-010 SHALL have port frame_done_o, output, 1, meaning one-cycle strobe coincident with the valid of sample N-1.
REQ-011 SHALL have port frame_err_o, output, 1, meaning one-cycle strobe on stop-bit error or start glitch.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; one cycle counter cnt and 3-bit bit index.
REQ-014 IDLE: rx_s==0 -> START, cnt=0.
REQ-015 START: at cnt==CLKS_PER_BIT/2-1, if rx_s==0 -> DATA with cnt=0, else -> IDLE with frame_err_o pulse (glitch); no byte produced.
REQ-016 DATA: at each cnt==CLKS_PER_BIT-1, shift rx_s into bit[index], cnt=0; after bit 7 -> STOP.
REQ-017 STOP: at cnt==CLKS_PER_BIT-1, rx_s==1 accepts the byte; rx_s==0 pulses frame_err_o, discards the byte, clears the byte-pair toggle; either case -> IDLE.
REQ-018 Accepted byte with pair toggle 0 SHALL be latched as low byte, toggle set to 1; no strobe.
REQ-019 Accepted byte with toggle 1: data_o={byte, low byte}, addr_o=sample counter, data_valid_o=1 on the next cycle; toggle cleared, counter incremented.
REQ-020 Sample counter SHALL wrap N-1 -> 0; frame_done_o=1 in the same cycle as data_valid_o when addr_o==N-1.
REQ-021 data_o/addr_o SHALL hold their values between strobes.
REQ-022 Back-to-back frames (next start bit immediately after the stop bit-period) SHALL be received without loss; IDLE re-arms the cycle after STOP sampling.
REQ-023 Framing error SHALL NOT reset the sample counter; only rst_n does.
REQ-024 Latency: data_valid_o SHALL assert exactly 2 (synchronizer) + 1 cycles after the stop bit mid-point on rx_i, i.e. mid-bit sampling with ±CLKS_PER_BIT/2 tolerance.
REQ-025 Line held low after an error SHALL NOT start a new byte until rx_s returns to 1 then falls.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state IDLE, cnt 0, toggle 0, sample counter 0, synchronizer 1, data_o 0, addr_o 0, data_valid_o 0, frame_done_o 0, frame_err_o 0.
REQ-027 Reset mid-byte SHALL discard the partial byte and pair; after release, reception resumes at the next falling edge seen after rx_s==1.

Verification
REQ-028 Bytes 0x34 then 0x12 at 10 clk/bit -> one strobe, data_o=0x1234, addr_o=0, frame_done_o=0.
REQ-029 N=256 ramp stream of 512 bytes 00,00,01,01,...,FF,FF back-to-back -> 256 strobes, data_o=0x0101*k at addr_o=k, frame_done_o only at k=255, then next frame addr_o=0.
REQ-030 Byte 0xA5 with stop bit 0, then 0x11,0x22 -> frame_err_o pulse, no strobe for 0xA5, next strobe data_o=0x2211 at unchanged addr_o.
REQ-031 rx_i low for 3 cycles then high -> frame_err_o pulse, no byte, no strobe, FSM back in IDLE.
REQ-032 rst_n pulsed low during bit 4 of the second byte of a pair -> all outputs 0; next pair 0x78,0x56 -> data_o=0x5678, addr_o=0.
REQ-033 N=4 with 8 pairs -> addr_o sequence 0,1,2,3,0,1,2,3 and two frame_done_o pulses.
